// File: rtl/vpu_fp_maxn_pkg.sv
// Shared constants for the VPU floating-point max/min reduction slice.
// Holds the default bf16 field widths, the mode encodings, the operand-count
// ceiling and a helper that builds the canonical quiet NaN for given widths.
package vpu_fp_maxn_pkg;

  localparam int FP_EXP_WIDTH    = 8;
  localparam int FP_MAN_WIDTH    = 7;
  localparam int FP_MAX_OPERANDS = 16;

  localparam logic FP_MODE_MAX = 1'b0;
  localparam logic FP_MODE_MIN = 1'b1;

  // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
  // Returned in a 32-bit container; callers slice the low 1+exp_w+man_w bits.
  function automatic logic [31:0] fp_canon_qnan(input int exp_w, input int man_w);
    logic [31:0] r;
    r = (((32'd1 << exp_w) - 32'd1) << man_w) | (32'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/vpu_fp_cmp_sel.sv
// Combinational two-operand floating-point compare-select (maxNum/minNum).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a (lower index), b (higher index), mode (0 max / 1 min),
//        result (selected value or canonical qNaN), sel_b (1 = b chosen).
module vpu_fp_cmp_sel
  import vpu_fp_maxn_pkg::*;
#(
  parameter  int EXP_WIDTH = FP_EXP_WIDTH,
  parameter  int MAN_WIDTH = FP_MAN_WIDTH,
  localparam int W         = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] result,
  output logic         sel_b
);

  localparam logic [31:0]  QNAN_FULL = fp_canon_qnan(EXP_WIDTH, MAN_WIDTH);
  localparam logic [W-1:0] QNAN      = QNAN_FULL[W-1:0];

  logic         a_nan;
  logic         b_nan;
  logic [W-1:0] a_key;
  logic [W-1:0] b_key;

  assign a_nan = (&a[W-2:MAN_WIDTH]) && (|a[MAN_WIDTH-1:0]);
  assign b_nan = (&b[W-2:MAN_WIDTH]) && (|b[MAN_WIDTH-1:0]);

  // Map sign-magnitude onto an unsigned total order: negatives are inverted,
  // positives get the top bit set. This orders -0 below +0 and keeps
  // subnormals and infinities in their natural places.
  assign a_key = a[W-1] ? ~a : {1'b1, a[W-2:0]};
  assign b_key = b[W-1] ? ~b : {1'b1, b[W-2:0]};

  always_comb begin
    sel_b  = 1'b0;
    result = a;
    if (a_nan && b_nan) begin
      result = QNAN;
    end else begin
      if (a_nan) begin
        sel_b = 1'b1;
      end else if (!b_nan) begin
        // Strict compare so that equal values keep a.
        sel_b = (mode == FP_MODE_MIN) ? (b_key < a_key) : (b_key > a_key);
      end
      result = sel_b ? b : a;
    end
  end

endmodule

// File: rtl/vpu_fp_maxn.sv
// Pipelined N-operand floating-point max/min reduction through a registered binary tree.
// Latency: clog2(NUM_OPERANDS) cycles start_i -> done_o; one new operation per cycle.
// Backpressure: none; every start_i is accepted. Optional macro VPU_FP_MAXN_ARGIDX_EN adds argidx_o.
// Ports: clk, rst (sync, active-high), operands_i (operand k at [k*W +: W]),
//        mode_i (0 max / 1 min), start_i, result_o, done_o, [argidx_o].
module vpu_fp_maxn
  import vpu_fp_maxn_pkg::*;
#(
  parameter  int NUM_OPERANDS = 4,
  parameter  int EXP_WIDTH    = FP_EXP_WIDTH,
  parameter  int MAN_WIDTH    = FP_MAN_WIDTH,
  localparam int W            = 1 + EXP_WIDTH + MAN_WIDTH,
  localparam int L            = $clog2(NUM_OPERANDS),
  localparam int IW           = (L < 1) ? 1 : L
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_OPERANDS*W-1:0] operands_i,
  input  logic                      mode_i,
  input  logic                      start_i,
  output logic [W-1:0]              result_o,
  output logic                      done_o
`ifdef VPU_FP_MAXN_ARGIDX_EN
  ,
  output logic [IW-1:0]             argidx_o
`endif
);

  if (NUM_OPERANDS < 2 || NUM_OPERANDS > FP_MAX_OPERANDS) begin : g_bad_num_operands
    $error("vpu_fp_maxn: NUM_OPERANDS must be in 2..16");
  end

  // Number of live elements at tree level l (level 0 = the input operands).
  function automatic int lvl_cnt(input int l);
    return (NUM_OPERANDS + (1 << l) - 1) >> l;
  endfunction

  for (genvar l = 1; l <= L; l++) begin : gen_lvl
    localparam int PC  = lvl_cnt(l - 1);
    localparam int CNT = lvl_cnt(l);

    logic [PC-1:0][W-1:0]  prev_dat;
    logic                  prev_vld;
    logic                  prev_mode;
    wire  [CNT-1:0][W-1:0] nxt_dat;
    logic [CNT-1:0][W-1:0] dat;
    logic                  vld;
`ifdef VPU_FP_MAXN_ARGIDX_EN
    wire  [PC-1:0][IW-1:0]  prev_idx;
    wire  [CNT-1:0][IW-1:0] nxt_idx;
    logic [CNT-1:0][IW-1:0] idx;
`endif

    if (l == 1) begin : g_src
      assign prev_dat  = operands_i;
      assign prev_vld  = start_i;
      assign prev_mode = mode_i;
`ifdef VPU_FP_MAXN_ARGIDX_EN
      for (genvar k = 0; k < PC; k++) begin : gen_idx0
        assign prev_idx[k] = IW'(k);
      end
`endif
    end else begin : g_src
      assign prev_dat  = gen_lvl[l-1].dat;
      assign prev_vld  = gen_lvl[l-1].vld;
      assign prev_mode = gen_lvl[l-1].g_mode.mode;
`ifdef VPU_FP_MAXN_ARGIDX_EN
      assign prev_idx  = gen_lvl[l-1].idx;
`endif
    end

    for (genvar j = 0; j < CNT; j++) begin : gen_node
      if (2 * j + 1 < PC) begin : g_pair
        logic sel_b;
        vpu_fp_cmp_sel #(
          .EXP_WIDTH (EXP_WIDTH),
          .MAN_WIDTH (MAN_WIDTH)
        ) u_cmp (
          .a      (prev_dat[2*j]),
          .b      (prev_dat[2*j+1]),
          .mode   (prev_mode),
          .result (nxt_dat[j]),
          .sel_b  (sel_b)
        );
`ifdef VPU_FP_MAXN_ARGIDX_EN
        assign nxt_idx[j] = sel_b ? prev_idx[2*j+1] : prev_idx[2*j];
`else
        logic unused_sel_b;
        assign unused_sel_b = sel_b;
`endif
      end else begin : g_pass
        // Odd element out at this level rides through unchanged.
        assign nxt_dat[j] = prev_dat[2*j];
`ifdef VPU_FP_MAXN_ARGIDX_EN
        assign nxt_idx[j] = prev_idx[2*j];
`endif
      end
    end

    // Data only loads on a valid beat, so the last level doubles as the
    // output register and holds its value between results.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= 1'b0;
        dat <= '0;
      end else begin
        vld <= prev_vld;
        if (prev_vld) begin
          dat <= nxt_dat;
        end
      end
    end

`ifdef VPU_FP_MAXN_ARGIDX_EN
    always_ff @(posedge clk) begin
      if (rst) begin
        idx <= '0;
      end else if (prev_vld) begin
        idx <= nxt_idx;
      end
    end
`endif

    // Mode rides along with each beat; the final level has no consumer for it.
    if (l < L) begin : g_mode
      logic mode;
      always_ff @(posedge clk) begin
        if (prev_vld) begin
          mode <= prev_mode;
        end
      end
    end
  end

  assign result_o = gen_lvl[L].dat[0];
  assign done_o   = gen_lvl[L].vld;
`ifdef VPU_FP_MAXN_ARGIDX_EN
  assign argidx_o = gen_lvl[L].idx[0];
`endif

endmodule

// File: tb/tb_vpu_fp_maxn.sv
// Scoreboard bench for vpu_fp_maxn at NUM_OPERANDS = 4, 5 and 2.
// Stimulus pushes hand-computed expectations; per-DUT monitors pop on done.
module tb_vpu_fp_maxn;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] res;
    int          idx;
    int          at;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];
  exp_t q2[$];
  exp_t e4, e5, e2;

  logic [63:0] ops4;
  logic [79:0] ops5;
  logic [31:0] ops2;
  logic        mode4, mode5, mode2;
  logic        start4, start5, start2;
  logic [15:0] res4, res5, res2;
  logic        done4, done5, done2;
`ifdef VPU_FP_MAXN_ARGIDX_EN
  logic [1:0]  idx4;
  logic [2:0]  idx5;
  logic [0:0]  idx2;
`endif

  vpu_fp_maxn #(.NUM_OPERANDS(4)) u4 (
    .clk(clk), .rst(rst), .operands_i(ops4), .mode_i(mode4), .start_i(start4),
    .result_o(res4), .done_o(done4)
`ifdef VPU_FP_MAXN_ARGIDX_EN
    , .argidx_o(idx4)
`endif
  );

  vpu_fp_maxn #(.NUM_OPERANDS(5)) u5 (
    .clk(clk), .rst(rst), .operands_i(ops5), .mode_i(mode5), .start_i(start5),
    .result_o(res5), .done_o(done5)
`ifdef VPU_FP_MAXN_ARGIDX_EN
    , .argidx_o(idx5)
`endif
  );

  vpu_fp_maxn #(.NUM_OPERANDS(2)) u2 (
    .clk(clk), .rst(rst), .operands_i(ops2), .mode_i(mode2), .start_i(start2),
    .result_o(res2), .done_o(done2)
`ifdef VPU_FP_MAXN_ARGIDX_EN
    , .argidx_o(idx2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: each done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) chk("u4 done with nothing pending", q4.size(), 1);
      else begin
        e4 = q4.pop_front();
        chk("u4 result", res4, e4.res);
        chk("u4 latency", cyc, e4.at);
`ifdef VPU_FP_MAXN_ARGIDX_EN
        chk("u4 argidx", idx4, e4.idx);
`endif
      end
    end
    if (done5 === 1'b1) begin
      if (q5.size() == 0) chk("u5 done with nothing pending", q5.size(), 1);
      else begin
        e5 = q5.pop_front();
        chk("u5 result", res5, e5.res);
        chk("u5 latency", cyc, e5.at);
`ifdef VPU_FP_MAXN_ARGIDX_EN
        chk("u5 argidx", idx5, e5.idx);
`endif
      end
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) chk("u2 done with nothing pending", q2.size(), 1);
      else begin
        e2 = q2.pop_front();
        chk("u2 result", res2, e2.res);
        chk("u2 latency", cyc, e2.at);
`ifdef VPU_FP_MAXN_ARGIDX_EN
        chk("u2 argidx", idx2, e2.idx);
`endif
      end
    end
  end

  // Each issue drives one beat right after a rising edge; it is sampled on
  // the next edge, so done is seen L cycles after the issue cycle.
  task automatic issue4(input logic [63:0] ops, input logic m, input logic [15:0] r, input int ix);
    @(posedge clk); #1;
    ops4 = ops; mode4 = m; start4 = 1'b1;
    q4.push_back('{r, ix, cyc + 2});
  endtask

  task automatic issue5(input logic [79:0] ops, input logic m, input logic [15:0] r, input int ix);
    @(posedge clk); #1;
    ops5 = ops; mode5 = m; start5 = 1'b1;
    q5.push_back('{r, ix, cyc + 3});
  endtask

  task automatic issue2(input logic [31:0] ops, input logic m, input logic [15:0] r, input int ix);
    @(posedge clk); #1;
    ops2 = ops; mode2 = m; start2 = 1'b1;
    q2.push_back('{r, ix, cyc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start4 = 1'b0; start5 = 1'b0; start2 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; start5 = 1'b0; start2 = 1'b0;
    mode4 = 1'b0;  mode5 = 1'b0;  mode2 = 1'b0;
    ops4 = '0; ops5 = '0; ops2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("u4 reset result", res4, 0);
    chk("u4 reset done", done4, 0);
    chk("u5 reset result", res5, 0);
    chk("u5 reset done", done5, 0);
    chk("u2 reset result", res2, 0);
    chk("u2 reset done", done2, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // N=4 directed vectors, back to back (operand 0 in the low bits).
    issue4({16'h0000, 16'hC040, 16'h4000, 16'h3F80}, 1'b0, 16'h4000, 1);
    issue4({16'h0000, 16'hC040, 16'h4000, 16'h3F80}, 1'b1, 16'hC040, 2);
    issue4({16'h8000, 16'h8000, 16'h0000, 16'h8000}, 1'b0, 16'h0000, 1);
    issue4({16'hFF80, 16'h7FA0, 16'h3F80, 16'h7FC0}, 1'b0, 16'h3F80, 1);
    issue4({16'h7FA0, 16'h7FA0, 16'h7FA0, 16'h7FA0}, 1'b0, 16'h7FC0, 0);
    issue4({16'h8002, 16'h8001, 16'h0002, 16'h0001}, 1'b0, 16'h0002, 1);
    issue4({16'h8002, 16'h8001, 16'h0002, 16'h0001}, 1'b1, 16'h8002, 3);
    issue4({16'h0000, 16'h3F80, 16'hFF80, 16'h7F80}, 1'b1, 16'hFF80, 1);
    issue4({16'h3F80, 16'h4000, 16'h3F80, 16'h4000}, 1'b0, 16'h4000, 0);
    idle(5);

    // N=5: six back-to-back beats alternating max/min; +inf rides the odd slot.
    issue5({16'h7F80, 16'h0000, 16'hC040, 16'h4000, 16'h3F80}, 1'b0, 16'h7F80, 4);
    issue5({16'h7F80, 16'h0000, 16'hC040, 16'h4000, 16'h3F80}, 1'b1, 16'hC040, 2);
    issue5({16'h7F80, 16'h4100, 16'h0001, 16'h8000, 16'h0000}, 1'b0, 16'h7F80, 4);
    issue5({16'h7F80, 16'h4100, 16'h0001, 16'h8000, 16'h0000}, 1'b1, 16'h8000, 1);
    issue5({16'h7F80, 16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80}, 1'b0, 16'h7F80, 4);
    issue5({16'h7F80, 16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7FC0}, 1'b1, 16'h7F80, 4);
    idle(6);

    // N=2: tie keeps operand 0, plus plain min/max.
    issue2({16'h3F80, 16'h3F80}, 1'b0, 16'h3F80, 0);
    issue2({16'h4000, 16'hC000}, 1'b1, 16'hC000, 0);
    issue2({16'h4000, 16'hC000}, 1'b0, 16'h4000, 1);
    idle(4);

    // Reset one cycle after a start, with another start during reset:
    // neither may complete.
    @(posedge clk); #1;
    ops4 = {16'h0000, 16'hC040, 16'h4000, 16'h3F80}; mode4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    ops4 = {16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80};
    @(posedge clk); #1;
    rst = 1'b0; start4 = 1'b0;
    @(negedge clk);
    chk("u4 result after mid-op reset", res4, 0);
    chk("u4 done after mid-op reset", done4, 0);
    idle(4);
    issue4({16'h0000, 16'hC040, 16'h4000, 16'h3F80}, 1'b1, 16'hC040, 2);
    idle(6);

    chk("u4 outstanding at end", q4.size(), 0);
    chk("u5 outstanding at end", q5.size(), 0);
    chk("u2 outstanding at end", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
